// File: rtl/usb_line_reader.sv
// Line assembler for the USB CDC receive path: pulls bytes from usb_uart and holds one
// newline-terminated line for a consumer. Optional feature macro: USB_LINE_READER_STRIP_CR_EN.
module usb_line_reader #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] TERM    = 8'h0A
) (
    input  logic                     clk_48mhz,
    input  logic                     resetn,
    output logic                     uart_re,
    input  logic [7:0]               uart_do,
    input  logic                     uart_wait,
    output logic                     line_valid,
    input  logic                     line_ready,
    output logic [$clog2(MAX_LEN):0] line_len,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]               rd_data,
    output logic                     overflow,
    output logic                     led,
    output logic [1:0]               state_dbg
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_LEN);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [CW-1:0]   len_nxt;
    logic            valid_nxt;
    logic            ovf_nxt;
    logic            led_nxt;
    logic            wr_en;
    logic            accept;
    logic            cr_drop;
    logic [7:0]      line_buf [MAX_LEN];

    // Handshakes: a byte moves when uart_re && !uart_wait in the same cycle; a line is
    // handed over while line_valid is high and is released on the first cycle line_ready is high.
    assign uart_re   = (state == FILL) || (state == DISCARD);
    assign accept    = uart_re && !uart_wait;
    assign state_dbg = state;

`ifdef USB_LINE_READER_STRIP_CR_EN
    assign cr_drop = (uart_do == 8'h0D);
`else
    assign cr_drop = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        len_nxt   = line_len;
        valid_nxt = line_valid;
        ovf_nxt   = 1'b0;
        led_nxt   = led;
        wr_en     = 1'b0;
        case (state)
            FILL: begin
                if (accept && !cr_drop) begin
                    if (uart_do == TERM) begin
                        // Empty lines are swallowed silently.
                        if (count != '0) begin
                            len_nxt   = count;
                            valid_nxt = 1'b1;
                            state_nxt = HOLD;
                        end
                    end else if (count < FULL) begin
                        wr_en     = 1'b1;
                        count_nxt = count + CW'(1);
                    end else begin
                        ovf_nxt   = 1'b1;
                        count_nxt = '0;
                        state_nxt = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (accept && !cr_drop && (uart_do == TERM)) begin
                    count_nxt = '0;
                    state_nxt = FILL;
                end
            end
            HOLD: begin
                if (line_ready) begin
                    valid_nxt = 1'b0;
                    count_nxt = '0;
                    led_nxt   = ~led;
                    state_nxt = FILL;
                end
            end
            default: begin
                count_nxt = '0;
                valid_nxt = 1'b0;
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            state      <= FILL;
            count      <= '0;
            line_len   <= '0;
            line_valid <= 1'b0;
            overflow   <= 1'b0;
            led        <= 1'b0;
            rd_data    <= 8'h00;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            line_len   <= len_nxt;
            line_valid <= valid_nxt;
            overflow   <= ovf_nxt;
            led        <= led_nxt;
            rd_data    <= line_buf[rd_addr];
        end
    end

    // Buffer storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk_48mhz) begin
        if (wr_en) begin
            line_buf[count[AW-1:0]] <= uart_do;
        end
    end

endmodule
